// File: rtl/uart_tx_scheduler_if.sv
// rtl/uart_tx_scheduler_if.sv - requester and UART handshake bundle for the transmit scheduler
// Ports (signals):
//   req_valid/req_data/req_last : per-requester byte offer (requester i uses req_data[8i+7:8i])
//   req_ready                   : one-hot accept strobe back to the requesters
//   uart_transmit/uart_tx_byte  : start pulse and byte towards the UART transmitter
//   uart_is_transmitting        : UART busy status
// Modports: master = requester/UART side, slave = scheduler.
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 uart_transmit;
  logic [7:0]           uart_tx_byte;
  logic                 uart_is_transmitting;

  modport master (
    output req_valid, req_data, req_last, uart_is_transmitting,
    input  req_ready, uart_transmit, uart_tx_byte
  );

  modport slave (
    input  req_valid, req_data, req_last, uart_is_transmitting,
    output req_ready, uart_transmit, uart_tx_byte
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin byte scheduler in front of a shared UART transmitter
// Ports:
//   clk         : clock, rising edge
//   rst         : synchronous active-low reset
//   bus         : requester handshakes and UART transmit/status (slave modport)
//   grant_id    : requester owning the current or last transfer
//   busy        : high whenever the FSM is not IDLE
//   err_timeout : one-cycle pulse when the UART never started a byte
module uart_tx_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 16,
  parameter int IDW           = 2
) (
  input  logic                clk,
  input  logic                rst,
  uart_tx_scheduler_if.slave  bus,
  output logic [IDW-1:0]      grant_id,
  output logic                busy,
  output logic                err_timeout
);
  localparam int CW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_START, WAIT_DONE} state_t;

  state_t         state_q, state_d;
  logic [7:0]     tx_hold_q, tx_hold_d;
  logic [IDW-1:0] last_grant_q, last_grant_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [IDW-1:0] lock_owner_q, lock_owner_d;
  logic           lock_q, lock_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] idx;
  logic [7:0]     win_byte;
  logic           win_last;

  // Winner selection. A locked message owner is the only candidate, even
  // while its valid is low, so message bytes never interleave.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    if (lock_q) begin
      win_found = bus.req_valid[lock_owner_q];
      win_id    = lock_owner_q;
    end else begin
      // Scan farthest-first so the nearest valid requester after last_grant
      // is the one left standing.
      for (int i = NUM_REQ; i >= 1; i--) begin
        idx = IDW'((int'(last_grant_q) + i) % NUM_REQ);
        if (bus.req_valid[idx]) begin
          win_found = 1'b1;
          win_id    = idx;
        end
      end
    end
  end

  always_comb begin
    win_byte = '0;
    win_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_id == IDW'(i)) begin
        win_byte = bus.req_data[8*i +: 8];
        win_last = bus.req_last[i];
      end
    end
  end

  always_comb begin
    state_d           = state_q;
    tx_hold_d         = tx_hold_q;
    last_grant_d      = last_grant_q;
    grant_id_d        = grant_id_q;
    lock_d            = lock_q;
    lock_owner_d      = lock_owner_q;
    cnt_d             = cnt_q;
    bus.req_ready     = '0;
    bus.uart_transmit = 1'b0;
    err_timeout       = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          bus.req_ready = NUM_REQ'(1) << win_id;
          tx_hold_d     = win_byte;
          last_grant_d  = win_id;
          grant_id_d    = win_id;
          lock_d        = !win_last;
          lock_owner_d  = win_id;
          state_d       = SEND;
        end
      end
      SEND: begin
        bus.uart_transmit = 1'b1;
        cnt_d             = '0;
        state_d           = WAIT_START;
      end
      WAIT_START: begin
        if (bus.uart_is_transmitting) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
          // The byte is dropped; releasing the lock lets others proceed.
          err_timeout = 1'b1;
          lock_d      = 1'b0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (!bus.uart_is_transmitting) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      tx_hold_q    <= '0;
      last_grant_q <= IDW'(NUM_REQ - 1);
      grant_id_q   <= '0;
      lock_q       <= 1'b0;
      lock_owner_q <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      tx_hold_q    <= tx_hold_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.uart_tx_byte = tx_hold_q;
  assign grant_id         = grant_id_q;
  assign busy             = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - self-checking bench for uart_tx_scheduler
module tb_uart_tx_scheduler;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant_id;
  logic       busy;
  logic       err_timeout;

  always #5 clk = ~clk;

  uart_tx_scheduler_if #(.NUM_REQ(N)) bus ();

  uart_tx_scheduler #(.NUM_REQ(N), .START_TIMEOUT(16), .IDW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .grant_id   (grant_id),
    .busy       (busy),
    .err_timeout(err_timeout)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Drive point: one time unit after the active edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int lim, input string name);
    int c;
    for (c = 0; c < lim; c++) begin
      cyc();
      #1;
      if (!busy) break;
    end
    chk(name, 32'(c < lim), 1);
  endtask

  // UART model: raises is_transmitting start_dly cycles after a start pulse,
  // holds it for tx_len cycles; a dead UART never responds.
  int start_dly = 1;
  int tx_len    = 2;
  bit uart_dead = 1'b0;

  initial begin
    bus.uart_is_transmitting = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.uart_transmit && !uart_dead) begin
        repeat (start_dly) @(posedge clk);
        #1 bus.uart_is_transmitting = 1'b1;
        repeat (tx_len) @(posedge clk);
        #1 bus.uart_is_transmitting = 1'b0;
      end
    end
  end

  typedef struct {
    logic [N-1:0] valid;
    logic         last;
    int           win;
  } vec_t;
  vec_t tbl [14];

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } rbyte_t;
  rbyte_t mem [N][16];
  int     head [N];
  int     tot  [N];
  bit     pres [N];

  logic [7:0] exp_lb [4] = '{8'h01, 8'h02, 8'h03, 8'h77};
  logic [1:0] exp_lg [4] = '{2'd1, 2'd1, 2'd1, 2'd0};
  logic [7:0] l1     [3] = '{8'h01, 8'h02, 8'h03};

  initial begin
    logic [N-1:0] exp_rdy;
    logic [7:0]   line_b [4];
    logic [1:0]   line_g [4];
    logic [7:0]   sb, r1_byte, exp_byte;
    logic [1:0]   sg, r1_gid;
    int c, k, gap, n_line, rc, tc, t_rdy, t_tx, t_err, t_r1, err_cnt, f_is, f_busy;
    int w, ri, age, cycl, m_last, m_owner, exp_id, len;
    bit acc, a3, r0_done, p_is, p_busy, busy_ae, got, inflight, started, m_lock, done;
    rbyte_t eb;

    tbl[0]  = '{4'b1111, 1'b1, 0};
    tbl[1]  = '{4'b1111, 1'b1, 1};
    tbl[2]  = '{4'b1111, 1'b1, 2};
    tbl[3]  = '{4'b1111, 1'b1, 3};
    tbl[4]  = '{4'b1111, 1'b1, 0};
    tbl[5]  = '{4'b0100, 1'b1, 2};
    tbl[6]  = '{4'b0100, 1'b1, 2};
    tbl[7]  = '{4'b1001, 1'b1, 3};
    tbl[8]  = '{4'b1001, 1'b1, 0};
    tbl[9]  = '{4'b0000, 1'b1, -1};
    tbl[10] = '{4'b0110, 1'b0, 1};
    tbl[11] = '{4'b0101, 1'b1, -1};
    tbl[12] = '{4'b0111, 1'b1, 1};
    tbl[13] = '{4'b0101, 1'b1, 2};

    rst           = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;

    // Reset state
    repeat (3) cyc();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_transmit", bus.uart_transmit, 0);
    chk("rst_tx_byte", bus.uart_tx_byte, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_ready", bus.req_ready, 0);
    cyc();
    rst = 1'b1;

    // Arbitration table, starting from reset priority
    for (int v = 0; v < 14; v++) begin
      cyc();
      bus.req_valid = tbl[v].valid;
      bus.req_last  = {N{tbl[v].last}};
      for (int i = 0; i < N; i++) bus.req_data[8*i +: 8] = 8'((v << 4) | i);
      #1;
      exp_rdy = (tbl[v].win < 0) ? '0 : (N'(1) << tbl[v].win);
      chk($sformatf("tbl%0d_ready", v), bus.req_ready, exp_rdy);
      if (tbl[v].win < 0) begin
        repeat (3) begin
          cyc();
          #1;
          chk($sformatf("tbl%0d_hold_ready", v), bus.req_ready, 0);
          chk($sformatf("tbl%0d_hold_busy", v), busy, 0);
        end
        cyc();
        bus.req_valid = '0;
      end else begin
        cyc();
        bus.req_valid = '0;
        #1;
        chk($sformatf("tbl%0d_transmit", v), bus.uart_transmit, 1);
        chk($sformatf("tbl%0d_byte", v), bus.uart_tx_byte, 32'((v << 4) | tbl[v].win));
        chk($sformatf("tbl%0d_grant", v), grant_id, tbl[v].win);
        wait_idle(40, $sformatf("tbl%0d_idle", v));
      end
    end

    // Single byte from requester 2, UART starts 3 cycles after the pulse
    start_dly = 3; tx_len = 4;
    rc = 0; tc = 0; t_rdy = -1; t_tx = -1; f_is = -1; f_busy = -1;
    p_is = 0; p_busy = 0; sb = 0; sg = 0; acc = 0;
    for (c = 0; c < 40; c++) begin
      cyc();
      bus.req_valid         = acc ? 4'b0000 : 4'b0100;
      bus.req_data[23:16]   = 8'hA5;
      bus.req_last          = 4'b0100;
      #1;
      if (bus.req_ready != 0) begin
        if (bus.req_ready == 4'b0100) rc++;
        else rc += 100;
        t_rdy = c;
        acc   = 1;
      end
      if (bus.uart_transmit) begin
        tc++; t_tx = c; sb = bus.uart_tx_byte; sg = grant_id;
      end
      if (p_is && !bus.uart_is_transmitting && f_is < 0) f_is = c;
      if (p_busy && !busy && f_busy < 0) f_busy = c;
      p_is   = bus.uart_is_transmitting;
      p_busy = busy;
    end
    chk("single_ready_cycles", rc, 1);
    chk("single_transmit_count", tc, 1);
    chk("single_latency", t_tx - t_rdy, 1);
    chk("single_byte", sb, 8'hA5);
    chk("single_grant", sg, 2);
    chk("single_busy_fall", f_busy - f_is, 1);

    // Message lock: requester 1 sends 3 bytes with gaps, requester 0 waits
    start_dly = 1; tx_len = 2;
    k = 0; gap = 0; r0_done = 0; n_line = 0;
    for (c = 0; c < 200 && n_line < 4; c++) begin
      cyc();
      bus.req_valid[1]    = (k < 3 && gap == 0);
      bus.req_data[15:8]  = l1[(k < 3) ? k : 2];
      bus.req_last[1]     = (k == 2);
      bus.req_valid[0]    = (k >= 1 && !r0_done);
      bus.req_data[7:0]   = 8'h77;
      bus.req_last[0]     = 1'b1;
      bus.req_valid[3:2]  = '0;
      #1;
      if (bus.uart_transmit && n_line < 4) begin
        line_b[n_line] = bus.uart_tx_byte;
        line_g[n_line] = grant_id;
        n_line++;
      end
      if (bus.req_ready[1]) begin k++; gap = 8; end
      else if (gap > 0) gap--;
      if (bus.req_ready[0]) r0_done = 1;
    end
    chk("lock_count", n_line, 4);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("lock_byte%0d", j), line_b[j], exp_lb[j]);
      chk($sformatf("lock_grant%0d", j), line_g[j], exp_lg[j]);
    end
    cyc();
    bus.req_valid = '0;
    wait_idle(40, "lock_idle");

    // Start timeout with a dead UART; requester 3 locked, then requester 1
    uart_dead = 1;
    t_tx = -1; t_err = -1; t_r1 = -1; err_cnt = 0; busy_ae = 1; a3 = 0;
    r1_byte = 0; r1_gid = 0;
    for (c = 0; c < 60; c++) begin
      cyc();
      if (err_cnt > 0) uart_dead = 0;
      bus.req_valid[3]    = !a3;
      bus.req_data[31:24] = 8'h5A;
      bus.req_last[3]     = 1'b0;
      bus.req_valid[1]    = a3 && (t_r1 < 0);
      bus.req_data[15:8]  = 8'h3C;
      bus.req_last[1]     = 1'b1;
      #1;
      if (bus.req_ready[3]) a3 = 1;
      if (bus.uart_transmit) begin
        if (t_tx < 0) t_tx = c;
        else begin r1_byte = bus.uart_tx_byte; r1_gid = grant_id; end
      end
      if (err_timeout) begin err_cnt++; t_err = c; end
      if (t_err >= 0 && c == t_err + 1) busy_ae = busy;
      if (bus.req_ready[1]) t_r1 = c;
    end
    chk("to_err_count", err_cnt, 1);
    chk("to_err_delay", t_err - t_tx, 16);
    chk("to_busy_after_err", busy_ae, 0);
    chk("to_next_grant_cycle", t_r1 - t_err, 1);
    chk("to_next_byte", r1_byte, 8'h3C);
    chk("to_next_grant_id", r1_gid, 1);
    cyc();
    bus.req_valid = '0;
    wait_idle(40, "to_idle");

    // Reset during WAIT_DONE
    start_dly = 1; tx_len = 10; acc = 0; got = 0;
    for (c = 0; c < 20; c++) begin
      cyc();
      bus.req_valid       = acc ? 4'b0000 : 4'b0100;
      bus.req_data[23:16] = 8'hC3;
      bus.req_last        = 4'b0000;
      #1;
      if (bus.req_ready[2]) acc = 1;
      if (busy && bus.uart_is_transmitting) begin got = 1; break; end
    end
    chk("mid_reach_wait_done", got, 1);
    cyc();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_transmit", bus.uart_transmit, 0);
    chk("mid_tx_byte", bus.uart_tx_byte, 0);
    chk("mid_grant_id", grant_id, 0);
    chk("mid_err", err_timeout, 0);
    chk("mid_ready", bus.req_ready, 0);
    got = 0;
    for (c = 0; c < 30; c++) begin
      if (!bus.uart_is_transmitting) begin got = 1; break; end
      cyc();
      #1;
    end
    chk("mid_uart_quiet", got, 1);
    cyc();
    bus.req_valid     = 4'b0011;
    bus.req_data[7:0] = 8'h44;
    bus.req_data[15:8] = 8'h55;
    bus.req_last      = 4'b0011;
    #1;
    chk("mid_first_ready", bus.req_ready, 4'b0001);
    cyc();
    bus.req_valid = '0;
    #1;
    chk("mid_first_transmit", bus.uart_transmit, 1);
    chk("mid_first_byte", bus.uart_tx_byte, 8'h44);
    chk("mid_first_grant", grant_id, 0);
    wait_idle(40, "mid_idle");

    // Randomized messages against a transaction-level arbitration model
    for (int i = 0; i < N; i++) begin
      tot[i] = 0; head[i] = 0; pres[i] = 0;
      for (int m = 0; m < 3; m++) begin
        len = $urandom_range(1, 3);
        for (int b = 0; b < len; b++) begin
          mem[i][tot[i]] = {8'($urandom), 1'(b == len - 1)};
          tot[i]++;
        end
      end
    end
    m_last = 0; m_lock = 0; m_owner = 0; inflight = 0; started = 0; age = 0;
    exp_byte = 0; exp_id = 0;
    cycl = 0;
    while (cycl < 4000) begin
      done = !inflight;
      for (int i = 0; i < N; i++) if (head[i] < tot[i]) done = 0;
      if (done) break;
      cyc();
      cycl++;
      if (!inflight) begin
        start_dly = $urandom_range(1, 4);
        tx_len    = $urandom_range(1, 5);
      end
      for (int i = 0; i < N; i++) begin
        if (!pres[i] && head[i] < tot[i] && $urandom_range(0, 2) != 0) pres[i] = 1;
        eb = (head[i] < tot[i]) ? mem[i][head[i]] : '0;
        bus.req_valid[i]       = pres[i];
        bus.req_data[8*i +: 8] = eb.data;
        bus.req_last[i]        = eb.last;
      end
      #1;
      chk("r_err", err_timeout, 0);
      if (!inflight) begin
        w = -1;
        if (m_lock) begin
          if (pres[m_owner]) w = m_owner;
        end else begin
          for (int j = 1; j <= N; j++) begin
            ri = (m_last + j) % N;
            if (pres[ri]) begin w = ri; break; end
          end
        end
        exp_rdy = (w < 0) ? '0 : (N'(1) << w);
        chk("r_ready", bus.req_ready, exp_rdy);
        chk("r_idle_busy", busy, 0);
        if (w >= 0) begin
          eb       = mem[w][head[w]];
          head[w]++;
          pres[w]  = 0;
          m_last   = w;
          m_owner  = w;
          m_lock   = !eb.last;
          exp_byte = eb.data;
          exp_id   = w;
          inflight = 1;
          age      = 0;
          started  = 0;
        end
      end else begin
        age++;
        chk("r_ready_busy", bus.req_ready, 0);
        chk("r_busy", busy, 1);
        chk("r_transmit", bus.uart_transmit, 32'(age == 1));
        if (age == 1) begin
          chk("r_byte", bus.uart_tx_byte, exp_byte);
          chk("r_grant", grant_id, exp_id);
        end else if (!started) begin
          started = bus.uart_is_transmitting;
        end else if (!bus.uart_is_transmitting) begin
          inflight = 0;
        end
      end
    end
    chk("r_complete", 32'(cycl < 4000), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
